frame_read: RTL and testbench

Display-side SDRAM frame fetcher. Latches the display block index published by the camera frame writer at each display frame start, issues 256-word Avalon read bursts for that block, and buffers returned data in an internal 512×32 FIFO. Serves 16-bit pixels to the HDMI timing/output stage through a valid/ready stream. Sits between the SDRAM arbiter port and the HDMI pixel pipeline, all in the SDRAM clock domain.

---
 rtl/frame_read.sv | 182 ++++++++++++++++++
 tb/tb_frame_read.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_read.sv
// frame_read: fetches one display frame from SDRAM in 256-word bursts into a 512x32 FIFO
// and serves it as a 16-bit RGB565 stream. Optional underflow counter: FRAME_READ_UNDERFLOW_CNT_EN.
module frame_read #(
  parameter logic [18:0] FRAME_WORDS = 19'd153600,
  parameter int          FIFO_DEPTH  = 512
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [1:0]  disp_block_num,
  input  logic        frame_start,
  output logic [31:0] avl_address,
  output logic        avl_read,
  output logic        avl_begin_burst_transfer,
  output logic [7:0]  avl_burst_count,
  input  logic        avl_request_ready,
  input  logic        avl_resp_valid,
  input  logic [31:0] avl_read_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_data,
  output logic [1:0]  cur_block_num,
  output logic        frame_busy
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
  ,
  output logic [15:0] underflow_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // A new burst is only requested when a whole burst is guaranteed to fit.
  localparam logic [CW-1:0] SPACE_LIMIT = CW'(FIFO_DEPTH - 256);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_RECV  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]    state_r;
  logic          restart_pend_r;
  logic          avl_read_r;
  logic          begin_burst_r;
  logic          frame_busy_r;
  logic [1:0]    cur_block_r;
  logic [18:0]   word_cnt_r;
  logic [7:0]    beat_cnt_r;
  logic          half_r;
  logic [31:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] used_r;

  logic          restart_req_s;
  logic          take_restart_s;
  logic          wr_en_s;
  logic          xfer_s;
  logic          rd_en_s;
  logic [31:0]   q_s;

  // Restart decode and FIFO strobes
  always_comb begin
    restart_req_s  = restart_pend_r | frame_start;
    take_restart_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_CHECK, ST_DONE: take_restart_s = restart_req_s;
      default:                    take_restart_s = 1'b0;
    endcase
    wr_en_s = (state_r == ST_RECV) && avl_resp_valid;
    xfer_s  = (used_r != {CW{1'b0}}) && pix_ready;
    rd_en_s = xfer_s && half_r;
  end

  // Frame sequencing: restart, space check, burst request, beat counting
  always_ff @(posedge clk) begin
    if (rest) begin
      state_r        <= ST_IDLE;
      restart_pend_r <= 1'b0;
      avl_read_r     <= 1'b0;
      begin_burst_r  <= 1'b0;
      frame_busy_r   <= 1'b0;
      cur_block_r    <= 2'd0;
      word_cnt_r     <= 19'd0;
      beat_cnt_r     <= 8'd0;
    end else begin
      restart_pend_r <= restart_req_s & ~take_restart_s;
      if (take_restart_s) begin
        state_r      <= ST_CHECK;
        word_cnt_r   <= 19'd0;
        cur_block_r  <= disp_block_num;
        frame_busy_r <= 1'b1;
      end else begin
        case (state_r)
          ST_CHECK: begin
            if (word_cnt_r == FRAME_WORDS) begin
              frame_busy_r <= 1'b0;
              state_r      <= ST_DONE;
            end else if (used_r <= SPACE_LIMIT) begin
              avl_read_r    <= 1'b1;
              begin_burst_r <= 1'b1;
              state_r       <= ST_REQ;
            end
          end
          ST_REQ: begin
            if (avl_request_ready) begin
              avl_read_r    <= 1'b0;
              begin_burst_r <= 1'b0;
              beat_cnt_r    <= 8'd0;
              state_r       <= ST_RECV;
            end
          end
          ST_RECV: begin
            if (avl_resp_valid) begin
              beat_cnt_r <= beat_cnt_r + 8'd1;
              if (beat_cnt_r == 8'd255) begin
                word_cnt_r <= word_cnt_r + 19'd256;
                state_r    <= ST_CHECK;
              end
            end
          end
          ST_IDLE, ST_DONE: state_r <= state_r;
          default:          state_r <= ST_IDLE;
        endcase
      end
    end
  end

  // FIFO pointers, occupancy and pixel half select; a restart flushes everything
  always_ff @(posedge clk) begin
    if (rest || take_restart_s) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      used_r   <= {CW{1'b0}};
      half_r   <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      if (xfer_s) begin
        half_r <= ~half_r;
      end
      used_r <= used_r + CW'(wr_en_s) - CW'(rd_en_s);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= avl_read_data;
    end
  end

`ifdef FRAME_READ_UNDERFLOW_CNT_EN
  logic [15:0] underflow_r;

  // Counts cycles the consumer wanted a pixel mid-frame and none was buffered
  always_ff @(posedge clk) begin
    if (rest || take_restart_s) begin
      underflow_r <= 16'd0;
    end else if (pix_ready && (used_r == {CW{1'b0}}) && frame_busy_r &&
                 (underflow_r != 16'hFFFF)) begin
      underflow_r <= underflow_r + 16'd1;
    end
  end

  assign underflow_cnt = underflow_r;
`endif

  assign q_s                      = mem_r[rd_ptr_r];
  assign avl_address              = {9'd0, cur_block_r, word_cnt_r, 2'd0};
  assign avl_read                 = avl_read_r;
  assign avl_begin_burst_transfer = begin_burst_r;
  assign avl_burst_count          = 8'd255;
  assign pix_valid                = (used_r != {CW{1'b0}});
  assign pix_data                 = half_r ? q_s[31:16] : q_s[15:0];
  assign cur_block_num            = cur_block_r;
  assign frame_busy               = frame_busy_r;

endmodule

// File: tb/tb_frame_read.sv
// Self-checking bench for frame_read: the bench acts as the Avalon slave and pixel sink,
// and predicts the pixel stream and frame status from a queue-based reference model.
module tb_frame_read;

  localparam logic [18:0] FW = 19'd1024;

  logic        clk = 1'b0;
  logic        rest;
  logic [1:0]  disp_block_num;
  logic        frame_start;
  logic [31:0] avl_address;
  logic        avl_read;
  logic        avl_begin_burst_transfer;
  logic [7:0]  avl_burst_count;
  logic        avl_request_ready;
  logic        avl_resp_valid;
  logic [31:0] avl_read_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic [1:0]  cur_block_num;
  logic        frame_busy;
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  always #5 clk = ~clk;

  frame_read #(.FRAME_WORDS(FW), .FIFO_DEPTH(512)) dut (
    .clk                      (clk),
    .rest                     (rest),
    .disp_block_num           (disp_block_num),
    .frame_start              (frame_start),
    .avl_address              (avl_address),
    .avl_read                 (avl_read),
    .avl_begin_burst_transfer (avl_begin_burst_transfer),
    .avl_burst_count          (avl_burst_count),
    .avl_request_ready        (avl_request_ready),
    .avl_resp_valid           (avl_resp_valid),
    .avl_read_data            (avl_read_data),
    .pix_valid                (pix_valid),
    .pix_ready                (pix_ready),
    .pix_data                 (pix_data),
    .cur_block_num            (cur_block_num),
    .frame_busy               (frame_busy)
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt            (underflow_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pixel queue in stream order plus frame bookkeeping
  logic [15:0] m_q[$];
  int          m_owed;
  int          m_fetched;
  int          m_bursts;
  logic        m_pend;
  logic        m_busy;
  logic [1:0]  m_blk;
  logic [15:0] m_uf;

  int pr_mode;
  bit rdy_rand;
  bit gap_rand;
  bit hold_resp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr();
    return 32'(m_blk) * 32'h0020_0000 + 32'(m_fetched) * 32'd4;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_owed    = 0;
    m_fetched = 0;
    m_bursts  = 0;
    m_pend    = 1'b0;
    m_busy    = 1'b0;
    m_blk     = 2'd0;
    m_uf      = 16'd0;
  endtask

  task automatic drive();
    avl_request_ready = rdy_rand ? 1'($urandom) : 1'b1;
    avl_resp_valid    = (m_owed > 0 && !hold_resp) ?
                        (gap_rand ? ($urandom_range(3) != 0) : 1'b1) : 1'b0;
    avl_read_data     = $urandom;
    case (pr_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = 1'b0;
      default: pix_ready = 1'($urandom);
    endcase
  endtask

  // One clock: advance the model with the inputs presented, then compare after the edge
  task automatic tick();
    bit bus_busy;
    bit taken;
    bit prev_read;
    int occ_pre;
    bus_busy  = avl_read || (m_owed > 0);
    taken     = (m_pend || frame_start) && !bus_busy;
    occ_pre   = (m_q.size() + 1) / 2;
    prev_read = avl_read;
    if (pix_ready && m_q.size() > 0) begin
      check("pix_data", 32'(pix_data), 32'(m_q[0]));
    end
    if (taken) m_uf = 16'd0;
    else if (pix_ready && m_q.size() == 0 && m_busy && m_uf != 16'hFFFF) m_uf = m_uf + 16'd1;
    if (pix_ready && m_q.size() > 0) void'(m_q.pop_front());
    if (avl_resp_valid && m_owed > 0) begin
      m_q.push_back(avl_read_data[15:0]);
      m_q.push_back(avl_read_data[31:16]);
      m_owed--;
      if (m_owed == 0) m_fetched += 256;
    end
    if (avl_read && avl_request_ready) begin
      m_owed = 256;
      m_bursts++;
    end
    if (taken) begin
      m_q.delete();
      m_blk     = disp_block_num;
      m_fetched = 0;
      m_bursts  = 0;
      m_busy    = 1'b1;
      m_pend    = 1'b0;
    end else begin
      m_pend = m_pend | frame_start;
      if (!bus_busy && m_fetched == int'(FW)) m_busy = 1'b0;
    end
    @(posedge clk);
    #1;
    check("pix_valid", 32'(pix_valid), 32'(m_q.size() != 0));
    check("frame_busy", 32'(frame_busy), 32'(m_busy));
    check("cur_block", 32'(cur_block_num), 32'(m_blk));
    if (avl_read) begin
      check("avl_address", avl_address, exp_addr());
      check("burst_count", 32'(avl_burst_count), 32'd255);
      check("begin_burst", 32'(avl_begin_burst_transfer), 32'd1);
    end
    if (avl_read && !prev_read) begin
      check("req_allowed", 32'(occ_pre <= 256 && m_busy && m_fetched < int'(FW)), 32'd1);
    end
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
    check("underflow_cnt", 32'(underflow_cnt), 32'(m_uf));
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      tick();
    end
  endtask

  task automatic pulse_start(input logic [1:0] blk);
    disp_block_num = blk;
    frame_start    = 1'b1;
    drive();
    tick();
    frame_start    = 1'b0;
  endtask

  task automatic wait_frame_end(input int budget, input string tag);
    int c = 0;
    while ((m_busy || m_q.size() != 0) && c < budget) begin
      drive();
      tick();
      c++;
    end
    check(tag, 32'(c < budget), 32'd1);
  endtask

  task automatic wait_owed(input int val, input int budget, input string tag);
    int c = 0;
    while (m_owed != val && c < budget) begin
      drive();
      tick();
      c++;
    end
    check(tag, 32'(c < budget), 32'd1);
  endtask

  task automatic do_reset(input bit stray);
    rest              = 1'b1;
    frame_start       = 1'b0;
    avl_resp_valid    = stray;
    avl_read_data     = $urandom;
    avl_request_ready = 1'b1;
    pix_ready         = 1'b1;
    @(posedge clk);
    #1;
    rest = 1'b0;
    model_clear();
    check("rst_avl_read", 32'(avl_read), 32'd0);
    check("rst_begin", 32'(avl_begin_burst_transfer), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_frame_busy", 32'(frame_busy), 32'd0);
    check("rst_cur_block", 32'(cur_block_num), 32'd0);
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
    check("rst_underflow", 32'(underflow_cnt), 32'd0);
`endif
  endtask

  initial begin
    logic [15:0] uf0;
    disp_block_num = 2'd0;
    pr_mode   = 0;
    rdy_rand  = 1'b0;
    gap_rand  = 1'b0;
    hold_resp = 1'b0;
    model_clear();
    do_reset(1'b0);
    do_reset(1'b0);

    // Restart latency and first request address
    pulse_start(2'd2);
    check("t1_block_n1", 32'(cur_block_num), 32'd2);
    check("t1_read_n1", 32'(avl_read), 32'd0);
    drive();
    tick();
    check("t1_read_n2", 32'(avl_read), 32'd1);
    check("t1_addr", avl_address, 32'h0040_0000);
    check("t1_burst", 32'(avl_burst_count), 32'd255);

    // Whole frame with zero-wait arbiter and always-ready sink
    wait_frame_end(6000, "t2_frame_timeout");
    check("t2_bursts", 32'(m_bursts), 32'(FW) / 32'd256);
    run(20);
    check("t2_no_extra_burst", 32'(m_bursts), 32'(FW) / 32'd256);
    check("t2_busy_low", 32'(frame_busy), 32'd0);

    // Stalled sink: two bursts fill the FIFO, then refill only after 256 words drain
    pr_mode = 1;
    pulse_start(2'd1);
    run(700);
    check("t3_bursts_full", 32'(m_bursts), 32'd2);
    check("t3_fill", 32'(m_q.size()), 32'd1024);
    check("t3_no_read", 32'(avl_read), 32'd0);
    pr_mode = 0;
    begin
      int c = 0;
      while (m_bursts < 3 && c < 800) begin
        drive();
        tick();
        c++;
      end
      check("t3_refill_timeout", 32'(c < 800), 32'd1);
    end
    pr_mode  = 2;
    rdy_rand = 1'b1;
    gap_rand = 1'b1;
    wait_frame_end(15000, "t3_frame_timeout");
    check("t3_bursts_total", 32'(m_bursts), 32'(FW) / 32'd256);

    // Restart mid-burst: burst drains, then flush and refetch from the new block
    pr_mode  = 1;
    rdy_rand = 1'b0;
    gap_rand = 1'b0;
    pulse_start(2'd0);
    wait_owed(156, 400, "t4_beat100_timeout");
    pulse_start(2'd3);
    wait_owed(0, 400, "t4_drain_timeout");
    check("t4_valid_before_flush", 32'(pix_valid), 32'd1);
    check("t4_block_kept", 32'(cur_block_num), 32'd0);
    drive();
    tick();
    check("t4_flush", 32'(pix_valid), 32'd0);
    check("t4_block_new", 32'(cur_block_num), 32'd3);
    drive();
    tick();
    check("t4_read", 32'(avl_read), 32'd1);
    check("t4_addr", avl_address, 32'h0060_0000);
    pr_mode = 0;
    wait_frame_end(6000, "t4_frame_timeout");

`ifdef FRAME_READ_UNDERFLOW_CNT_EN
    // Starved sink during a frame, then clear on the next restart
    pulse_start(2'd2);
    wait_owed(256, 100, "t5_req_timeout");
    uf0       = m_uf;
    hold_resp = 1'b1;
    run(40);
    check("t5_underflow_40", 32'(underflow_cnt), 32'(uf0) + 32'd40);
    hold_resp = 1'b0;
    wait_frame_end(6000, "t5_frame_timeout");
    pulse_start(2'd1);
    check("t5_underflow_clr", 32'(underflow_cnt), 32'd0);
    wait_frame_end(6000, "t5_frame2_timeout");
`endif

    // Reset in the middle of a burst, then stray beats
    pulse_start(2'd1);
    wait_owed(200, 400, "t6_recv_timeout");
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      avl_resp_valid    = 1'b1;
      avl_read_data     = $urandom;
      avl_request_ready = 1'b1;
      pix_ready         = 1'b1;
      tick();
      check("t6_stray_valid", 32'(pix_valid), 32'd0);
      check("t6_stray_read", 32'(avl_read), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
